// File: rtl/c1541_pkg.sv
// Shared types for the c1541 SD channel arbiter.
// Holds the arbiter state enum, drive limit and index-width helper.
package c1541_pkg;

  localparam int C1541_MAX_DRIVES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    GAP
  } arb_state_t;

  // Width of a drive index; never zero so 1-drive builds stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/c1541_sd_if.sv
// Host-side MiSTer SD block channel (request, ack, buffer bus).
// master: arbiter drives lba/rd/wr/din; slave: host drives ack/buff_wr.
interface c1541_sd_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_wr
  );
endinterface

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin picker: first eligible drive after last.
// In: eligible, last. Out: valid, idx.
module c1541_rr_pick
  import c1541_pkg::*;
#(
  parameter int NDRIVES = 4,
  parameter int IW      = idx_w(NDRIVES)
) (
  input  logic [NDRIVES-1:0] eligible,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  // Scan farthest-first so the nearest candidate after last wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NDRIVES; k >= 1; k--) begin
      if (eligible[IW'((int'(last) + k) % NDRIVES)]) begin
        valid = 1'b1;
        idx   = IW'((int'(last) + k) % NDRIVES);
      end
    end
  end

endmodule

// File: rtl/c1541_sd_arb.sv
// Round-robin share of one SD block channel among c1541_sd drives.
// Ports: clk_sys, reset_n, drv_* per-drive bus, sd host if, busy.
module c1541_sd_arb
  import c1541_pkg::*;
#(
  parameter int NDRIVES = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [32*NDRIVES-1:0]   drv_lba,
  input  logic [NDRIVES-1:0]      drv_rd,
  input  logic [NDRIVES-1:0]      drv_wr,
  output logic [NDRIVES-1:0]      drv_ack,
  input  logic [8*NDRIVES-1:0]    drv_buff_din,
  output logic [NDRIVES-1:0]      drv_buff_wr,
  c1541_sd_if.master              sd,
  output logic                    busy
);

  localparam int IW = idx_w(NDRIVES);

  arb_state_t          state_q;
  logic [IW-1:0]       grant_q;
  logic [IW-1:0]       last_q;
  logic [NDRIVES-1:0]  served_q;
  logic [NDRIVES-1:0]  served_d;
  logic [31:0]         lba_q;
  logic                rd_q;
  logic                wr_q;

  logic [31:0]         lba_a [NDRIVES];
  logic [7:0]          din_a [NDRIVES];
  logic [NDRIVES-1:0]  req;
  logic [NDRIVES-1:0]  eligible;
  logic                pick_v;
  logic [IW-1:0]       pick_i;

  for (genvar g = 0; g < NDRIVES; g++) begin : g_unpack
    assign lba_a[g] = drv_lba[32*g +: 32];
    assign din_a[g] = drv_buff_din[8*g +: 8];
  end

  assign req      = drv_rd | drv_wr;
  assign eligible = req & ~served_q;

  c1541_rr_pick #(
    .NDRIVES (NDRIVES),
    .IW      (IW)
  ) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .valid    (pick_v),
    .idx      (pick_i)
  );

  // A drive stays served until it drops both requests, so a held
  // level cannot win a second grant.
  always_comb begin
    served_d = served_q & req;
    if (state_q == XFER && !sd.sd_ack) begin
      served_d[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IW'(NDRIVES - 1);
      served_q <= '0;
      lba_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      served_q <= served_d;
      unique case (state_q)
        IDLE: begin
          if (pick_v) begin
            grant_q <= pick_i;
            last_q  <= pick_i;
            lba_q   <= lba_a[pick_i];
            wr_q    <= drv_wr[pick_i];
            rd_q    <= ~drv_wr[pick_i];
            state_q <= REQ;
          end
        end
        REQ: begin
          if (sd.sd_ack) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (!sd.sd_ack) begin
            state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sd.sd_lba      = lba_q;
  assign sd.sd_rd       = rd_q;
  assign sd.sd_wr       = wr_q;
  assign sd.sd_buff_din = din_a[grant_q];
  assign busy           = (state_q != IDLE);

  always_comb begin
    drv_ack     = '0;
    drv_buff_wr = '0;
    if (state_q == XFER) begin
      drv_ack[grant_q]     = sd.sd_ack;
      drv_buff_wr[grant_q] = sd.sd_buff_wr;
    end
  end

endmodule

// File: tb/tb_c1541_sd_arb.sv
// Scoreboard bench for c1541_sd_arb with four drives.
// Host model serves grants; expected grants are queued at stimulus.
module tb_c1541_sd_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  drv_rd;
  logic [3:0]  drv_wr;
  logic [3:0]  drv_ack;
  logic [3:0]  drv_buff_wr;
  logic [31:0] lba_a [4];
  logic [7:0]  din_a [4];
  logic [127:0] drv_lba;
  logic [31:0] drv_buff_din;
  logic        busy;

  c1541_sd_if sd_bus ();

  assign drv_lba      = {lba_a[3], lba_a[2], lba_a[1], lba_a[0]};
  assign drv_buff_din = {din_a[3], din_a[2], din_a[1], din_a[0]};

  always #5 clk = ~clk;

  c1541_sd_arb #(.NDRIVES(4)) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .drv_lba      (drv_lba),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .drv_buff_wr  (drv_buff_wr),
    .sd           (sd_bus),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] lba;
    logic        wr;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         fails  = 0;
  logic [3:0] hold;

  task automatic push(input logic [1:0] i,
                      input logic [31:0] l,
                      input logic w);
    exp_t e;
    e.idx = i;
    e.lba = l;
    e.wr  = w;
    q.push_back(e);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    drv_rd  = '0;
    drv_wr  = '0;
    hold    = '0;
    for (int i = 0; i < 4; i++) begin
      lba_a[i] = '0;
      din_a[i] = '0;
    end
    sd_bus.sd_ack     = 1'b0;
    sd_bus.sd_buff_wr = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Host model: wait for a request, check it against the queue,
  // then run one ack window of nstb buffer strobes.
  task automatic serve(input int nstb, input int rr,
                       input logic [31:0] rlba, output int lat);
    exp_t       e;
    logic [3:0] m;
    int         pulses;
    int         bad;
    bit         seen;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 64 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (sd_bus.sd_rd || sd_bus.sd_wr) begin
        seen = 1;
        lat  = c;
      end
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL req_timeout: no sd_rd/sd_wr, want one in 64");
      return;
    end
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_req: lba=%h, want none",
               sd_bus.sd_lba);
      return;
    end
    e = q.pop_front();
    m = 4'b0001 << e.idx;
    checks++;
    if (sd_bus.sd_lba !== e.lba) begin
      fails++;
      $display("FAIL sd_lba: got %h, want %h", sd_bus.sd_lba, e.lba);
    end
    checks++;
    if ({sd_bus.sd_wr, sd_bus.sd_rd} !== (e.wr ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL rd_wr: got wr=%b rd=%b, want wr=%b rd=%b",
               sd_bus.sd_wr, sd_bus.sd_rd, e.wr, ~e.wr);
    end
    sd_bus.sd_ack = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({sd_bus.sd_wr, sd_bus.sd_rd} !== 2'b00 || drv_ack !== m) begin
      fails++;
      $display("FAIL ack_start: got rdwr=%b%b ack=%b, want 00 %b",
               sd_bus.sd_rd, sd_bus.sd_wr, drv_ack, m);
    end
    if (!hold[e.idx]) begin
      drv_rd[e.idx] = 1'b0;
      drv_wr[e.idx] = 1'b0;
    end
    if (rr >= 0) begin
      drv_rd[2'(rr)] = 1'b1;
      lba_a[rr]      = rlba;
      push(2'(rr), rlba, 1'b0);
    end
    pulses = 0;
    bad    = 0;
    for (int k = 0; k < nstb; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        din_a[d] = (d == int'(e.idx)) ? 8'(k) : 8'(8'hE0 + d);
      end
      sd_bus.sd_buff_wr = 1'b1;
      #1;
      if (drv_buff_wr === m) pulses++;
      if (sd_bus.sd_buff_din !== 8'(k)) bad++;
      if (drv_ack !== m) bad++;
      @(negedge clk);
      sd_bus.sd_buff_wr = 1'b0;
      #1;
      if (drv_buff_wr !== 4'b0) bad++;
    end
    checks++;
    if (pulses != nstb) begin
      fails++;
      $display("FAIL buff_wr_pulses: got %0d, want %0d", pulses, nstb);
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL xfer_bus: got %0d bad samples, want 0", bad);
    end
    @(negedge clk);
    sd_bus.sd_ack = 1'b0;
    #1;
    checks++;
    if (drv_ack !== 4'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ack_fall: got ack=%b busy=%b, want 0000 1",
               drv_ack, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || sd_bus.sd_rd || sd_bus.sd_wr) begin
      fails++;
      $display("FAIL gap: got busy=%b rd=%b wr=%b, want 1 0 0",
               busy, sd_bus.sd_rd, sd_bus.sd_wr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_gap: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({busy, sd_bus.sd_rd, sd_bus.sd_wr} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctl: got busy/rd/wr=%b%b%b, want 000",
               busy, sd_bus.sd_rd, sd_bus.sd_wr);
    end
    checks++;
    if (sd_bus.sd_lba !== 32'h0) begin
      fails++;
      $display("FAIL reset_lba: got %h, want 0", sd_bus.sd_lba);
    end
    sd_bus.sd_ack     = 1'b1;
    sd_bus.sd_buff_wr = 1'b1;
    #1;
    checks++;
    if (drv_ack !== 4'b0 || drv_buff_wr !== 4'b0) begin
      fails++;
      $display("FAIL idle_gate: got ack=%b bwr=%b, want 0 0",
               drv_ack, drv_buff_wr);
    end
    @(negedge clk);
    sd_bus.sd_ack     = 1'b0;
    sd_bus.sd_buff_wr = 1'b0;
  endtask

  task automatic test_single_read();
    int lat;
    @(negedge clk);
    drv_rd[1] = 1'b1;
    lba_a[1]  = 32'h0000_0123;
    push(2'd1, 32'h0000_0123, 1'b0);
    serve(512, -1, 32'h0, lat);
    checks++;
    if (lat != 1) begin
      fails++;
      $display("FAIL read_latency: got %0d, want 1", lat);
    end
  endtask

  task automatic test_round_robin();
    int lat;
    apply_reset();
    drv_rd[0] = 1'b1;
    drv_rd[2] = 1'b1;
    drv_rd[3] = 1'b1;
    lba_a[0]  = 32'h0000_1000;
    lba_a[2]  = 32'h0000_2000;
    lba_a[3]  = 32'h0000_3000;
    push(2'd0, 32'h0000_1000, 1'b0);
    push(2'd2, 32'h0000_2000, 1'b0);
    push(2'd3, 32'h0000_3000, 1'b0);
    serve(4, -1, 32'h0, lat);
    serve(4, 0, 32'h0000_1001, lat);
    serve(4, -1, 32'h0, lat);
    serve(4, -1, 32'h0, lat);
  endtask

  task automatic test_write();
    int lat;
    @(negedge clk);
    drv_wr[3] = 1'b1;
    lba_a[3]  = 32'hABCD_0003;
    push(2'd3, 32'hABCD_0003, 1'b1);
    serve(16, -1, 32'h0, lat);
  endtask

  task automatic test_no_double();
    int  lat;
    bit  regrant;
    @(negedge clk);
    hold[0]   = 1'b1;
    drv_rd[0] = 1'b1;
    lba_a[0]  = 32'h0000_0777;
    push(2'd0, 32'h0000_0777, 1'b0);
    serve(4, -1, 32'h0, lat);
    regrant = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (sd_bus.sd_rd || sd_bus.sd_wr || busy) regrant = 1;
    end
    checks++;
    if (regrant) begin
      fails++;
      $display("FAIL no_double: got second grant, want none");
    end
    drv_rd[0] = 1'b0;
    hold[0]   = 1'b0;
    @(negedge clk);
    drv_rd[0] = 1'b1;
    lba_a[0]  = 32'h0000_0778;
    push(2'd0, 32'h0000_0778, 1'b0);
    serve(4, -1, 32'h0, lat);
  endtask

  task automatic test_rd_wr_both();
    int lat;
    @(negedge clk);
    drv_rd[2] = 1'b1;
    drv_wr[2] = 1'b1;
    lba_a[2]  = 32'h0000_0222;
    push(2'd2, 32'h0000_0222, 1'b1);
    serve(4, -1, 32'h0, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(negedge clk);
    drv_rd[1] = 1'b1;
    lba_a[1]  = 32'h0000_0055;
    seen = 0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (sd_bus.sd_rd) seen = 1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL mid_req: no sd_rd, want one");
    end
    sd_bus.sd_ack = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (drv_ack !== 4'b0010) begin
      fails++;
      $display("FAIL mid_xfer: got ack=%b, want 0010", drv_ack);
    end
    reset_n           = 1'b0;
    sd_bus.sd_buff_wr = 1'b1;
    #1;
    checks++;
    if ({sd_bus.sd_rd, sd_bus.sd_wr, busy} !== 3'b000 ||
        drv_ack !== 4'b0 || drv_buff_wr !== 4'b0) begin
      fails++;
      $display("FAIL mid_reset: got rd/wr/busy=%b%b%b ack=%b bwr=%b",
               sd_bus.sd_rd, sd_bus.sd_wr, busy, drv_ack, drv_buff_wr);
    end
    @(negedge clk);
    sd_bus.sd_ack     = 1'b0;
    sd_bus.sd_buff_wr = 1'b0;
    @(negedge clk);
    drv_rd[0] = 1'b1;
    lba_a[0]  = 32'h0000_0abc;
    push(2'd0, 32'h0000_0abc, 1'b0);
    push(2'd1, 32'h0000_0055, 1'b0);
    reset_n = 1'b1;
    serve(4, -1, 32'h0, lat);
    checks++;
    if (lat != 1) begin
      fails++;
      $display("FAIL post_reset_latency: got %0d, want 1", lat);
    end
    serve(4, -1, 32'h0, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_no_double();
    test_rd_wr_both();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/c1541_sd_arb.md
# c1541_sd_arb

Shares one MiSTer SD block channel (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack` plus the 512-byte buffer bus) between up to four `c1541_sd` drive instances. It runs in the `clk_sys` domain, between the HPS-side SD block interface and the per-drive SD ports. It grants the channel to one drive at a time using round-robin arbitration. It serialises one complete sector transfer per grant and routes the buffer bus to the granted drive only.

## Interface
Parameters:
- `NDRIVES`, 4, number of drive ports (1..4).

Ports:
- `clk_sys` in 1: system clock; all logic is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `drv_lba` in 32*NDRIVES: per-drive LBA; drive i uses bits [32i+31:32i].
- `drv_rd` in NDRIVES: per-drive read request; level signal, held until that drive's ack rises.
- `drv_wr` in NDRIVES: per-drive write request; same protocol as `drv_rd`.
- `drv_ack` out NDRIVES: per-drive ack; copy of `sd_ack` for the granted drive, 0 for all others.
- `drv_buff_din` in 8*NDRIVES: per-drive write data returned to the buffer bus.
- `drv_buff_wr` out NDRIVES: per-drive gated `sd_buff_wr`.
- `sd_lba` out 32: LBA of the granted transfer.
- `sd_rd`, `sd_wr` out 1: request to the host.
- `sd_ack` in 1: host ack.
- `sd_buff_wr` in 1: host buffer write strobe.
- `sd_buff_din` out 8: write data from the granted drive.
- `busy` out 1: high whenever state ≠ IDLE.

`sd_buff_addr` and `sd_buff_dout` are broadcast to all drives outside this block.

## Operation
- FSM states: IDLE, REQ, XFER, GAP.
- **IDLE:**
  - A drive is eligible when `drv_rd[i] | drv_wr[i]` is high and `served[i]` is 0.
  - The winner is the first eligible drive, searching from `last+1` upward and wrapping modulo NDRIVES.
  - On a winner: latch `grant` and `last` = i, latch `sd_lba` from `drv_lba[i]`, latch `op_wr` = `drv_wr[i]`, and go to REQ.
  - If both `drv_rd[i]` and `drv_wr[i]` are high, write wins.
- **REQ:**
  - `sd_wr` = `op_wr`; `sd_rd` = ~`op_wr`.
  - When `sd_ack` is sampled high, clear both and go to XFER.
  - A withdrawn drive request in this state has no effect; the transfer completes.
- **XFER:**
  - `drv_ack[grant]` = `sd_ack`.
  - `drv_buff_wr[grant]` = `sd_buff_wr`.
  - `sd_buff_din` = `drv_buff_din[grant]`.
  - When `sd_ack` is sampled low, set `served[grant]` and go to GAP.
- **GAP:** one cycle, then IDLE.
- `served[i]` clears in any cycle where `drv_rd[i]` and `drv_wr[i]` are both low. A drive therefore cannot be granted twice for one request edge.
- Outside XFER, all `drv_ack` and `drv_buff_wr` bits are 0.
- `sd_buff_din` mux is combinational on the registered `grant`; it holds the last grant when idle.
- Reset values: state IDLE, `grant` 0, `last` NDRIVES-1 (drive 0 wins first), `served` 0, `sd_lba` 0, `sd_rd`/`sd_wr` 0, `busy` 0, `drv_ack` 0.
- Reset mid-transfer drops `sd_rd`/`sd_wr` immediately. A host ack still in flight is ignored: it reaches no drive, because state is IDLE.

## Timing
- Request sampled in IDLE at cycle N → `sd_rd`/`sd_wr` and `sd_lba` are valid (registered) at N+1.
- `sd_ack` sampled high at M → `sd_rd`/`sd_wr` low at M+1. `drv_ack` follows `sd_ack` combinationally, with zero latency, while in XFER.
- `sd_ack` sampled low at K → GAP at K+1, IDLE at K+2. The earliest next `sd_rd`/`sd_wr` is at K+3.
- `drv_buff_wr` and `sd_buff_din` are combinational passes, so the buffer bus adds no latency.
- Requests that arrive while `busy` is high stay pending and are never dropped.

## Structure
- Shared package `c1541_pkg`:
  - state enum `arb_state_t` {IDLE, REQ, XFER, GAP};
  - constant `C1541_MAX_DRIVES` = 4.
- One sub-module, `c1541_rr_pick`: a combinational round-robin picker. Inputs: `eligible[NDRIVES]`, `last`. Outputs: `valid`, `idx`.
- All sequential logic lives in `c1541_sd_arb`.

## Test plan
- **Single read:** drive 1 raises `drv_rd` with LBA 0x00000123 → `sd_rd`=1 and `sd_lba`=0x123 one cycle later. Host acks for 512 `sd_buff_wr` strobes → only `drv_buff_wr[1]` pulses 512 times; `drv_ack[1]` mirrors `sd_ack`.
- **Round-robin:** drives 0, 2, 3 request simultaneously after reset → served in order 0, 2, 3. Drive 0 re-requests during drive 2's transfer → it is served after drive 3.
- **Write path:** drive 3 writes, `drv_buff_din[3]` = address LSBs → `sd_buff_din` equals them during XFER; `sd_wr`=1 and `sd_rd`=0.
- **No double service:** drive 0 holds `drv_rd` high past ack fall → no second grant until `drv_rd` is seen low and then raised again.
- **rd+wr together:** drive 2 asserts both → `sd_wr` issued, `sd_rd` stays 0.
- **Reset mid-XFER:** assert `reset_n`=0 during XFER → `sd_rd`/`sd_wr`/`drv_ack`/`busy` are all 0 in the same cycle. After release, drive 0 is served first.
